// File: rtl/esc_quad_pwm.sv
// esc_quad_pwm: four-channel ESC PWM generator with frame-aligned double-buffered speed updates.
// Optional failsafe watchdog is compiled in with `define ESC_QUAD_WDOG_EN.
module esc_quad_pwm #(
    parameter int PERIOD_CYC  = 125000,
    parameter int MIN_PW      = 50000,
    parameter int SCALE       = 24,
    parameter int WDOG_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        frnt,
    output logic        bck,
    output logic        lft,
    output logic        rght,
    output logic        frm_strt,
    output logic        stale
);
    localparam int CW = $clog2(PERIOD_CYC);
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

    if (PERIOD_CYC <= MIN_PW + 2047 * SCALE || WDOG_FRAMES < 1) begin : g_cfg_err
        $error("esc_quad_pwm: PERIOD_CYC cannot hold a full-scale pulse");
    end

    logic [CW-1:0] cnt;
    logic [3:0][10:0] shd, act;
    logic [CW-1:0] wid [4];
    logic [3:0] pwm;
    logic pend, wrap;

    assign wrap = cnt == LAST;
    assign {rght, lft, bck, frnt} = pwm;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= wrap ? '0 : cnt + 1'b1;

    // a write landing on the wrap edge stays pending for the following wrap
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shd  <= '0;
            pend <= 1'b0;
        end else begin
            if (wrt) shd <= {rght_spd, lft_spd, bck_spd, frnt_spd};
            pend <= wrt | (pend & ~wrap);
        end

`ifdef ESC_QUAD_WDOG_EN
    localparam int WW = $clog2(WDOG_FRAMES + 1);
    logic [WW-1:0] wcnt;
    logic stl;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wcnt <= '0;
            stl  <= 1'b1;
            act  <= '0;
        end else begin
            if (wrt) wcnt <= '0;
            else if (wrap && wcnt != WW'(WDOG_FRAMES)) wcnt <= wcnt + 1'b1;
            if (wrap && pend) begin
                act <= shd;
                stl <= 1'b0;
            end else if (wrap && wcnt == WW'(WDOG_FRAMES)) begin
                act <= '0;
                stl <= 1'b1;
            end
        end

    assign stale = stl;
`else
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) act <= '0;
        else if (wrap && pend) act <= shd;

    assign stale = 1'b0;
`endif

    always_comb
        for (int i = 0; i < 4; i++) wid[i] = CW'(MIN_PW) + CW'(SCALE) * CW'(act[i]);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pwm      <= '0;
            frm_strt <= 1'b0;
        end else begin
            frm_strt <= cnt == '0;
            for (int i = 0; i < 4; i++) pwm[i] <= cnt < wid[i];
        end
endmodule
